scoreboard_regfile: RTL and testbench

SCOREBOARD_REGFILE -- requirements
Module: scoreboard_regfile

---
 rtl/scoreboard_regfile_pkg.sv | 7 +
 rtl/scoreboard_regfile_busy_tracker.sv | 48 ++++
 rtl/scoreboard_regfile.sv | 69 ++++++
 tb/tb_scoreboard_regfile.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/scoreboard_regfile_pkg.sv
// Shared core constants for the register file: default geometry and the
// hardwired zero-register index used by decode, execute and the regfile.
package scoreboard_regfile_pkg;
   localparam int SB_ADDR_WIDTH = 5;
   localparam int SB_DATA_WIDTH = 64;
   localparam int SB_ZERO_REG   = 0;
endpackage

// File: rtl/scoreboard_regfile_busy_tracker.sv
// Pending-write scoreboard: one busy bit per register plus a registered
// popcount of the bits that are set.
module busy_tracker
   import scoreboard_regfile_pkg::*;
#(
   parameter int ADDR_WIDTH = SB_ADDR_WIDTH
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         iss_en,
   input  logic [ADDR_WIDTH-1:0]        iss_addr,
   input  logic                         wb_en,
   input  logic [ADDR_WIDTH-1:0]        wb_addr,
   input  logic                         flush,
   output logic [(1<<ADDR_WIDTH)-1:0]   busy_o,
   output logic [ADDR_WIDTH:0]          cnt_o
);
   localparam int NREG = 1 << ADDR_WIDTH;
   localparam logic [ADDR_WIDTH-1:0] ZERO = ADDR_WIDTH'(SB_ZERO_REG);

   logic [NREG-1:0]     busy_q, busy_d;
   logic [ADDR_WIDTH:0] cnt_q, cnt_d;

   // Applied in order so a same-cycle issue beats the writeback and flush beats both.
   always_comb begin
      busy_d = busy_q;
      cnt_d  = '0;
      if (wb_en && wb_addr != ZERO)   busy_d[wb_addr]  = 1'b0;
      if (iss_en && iss_addr != ZERO) busy_d[iss_addr] = 1'b1;
      if (flush)                      busy_d           = '0;
      busy_d[ZERO] = 1'b0;
      for (int i = 0; i < NREG; i++)
         cnt_d = cnt_d + {{ADDR_WIDTH{1'b0}}, busy_d[i]};
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         busy_q <= '0;
         cnt_q  <= '0;
      end else begin
         busy_q <= busy_d;
         cnt_q  <= cnt_d;
      end
   end

   assign busy_o = busy_q;
   assign cnt_o  = cnt_q;
endmodule

// File: rtl/scoreboard_regfile.sv
// Register file with zero-latency read ports, same-cycle writeback bypass and
// a pending-write scoreboard for hazard detection.
module scoreboard_regfile
   import scoreboard_regfile_pkg::*;
#(
   parameter int ADDR_WIDTH = SB_ADDR_WIDTH,
   parameter int DATA_WIDTH = SB_DATA_WIDTH,
   parameter int NUM_RD     = 2
) (
   input  logic                           clk,
   input  logic                           rst_n,
   input  logic [NUM_RD*ADDR_WIDTH-1:0]   rs_addr,
   output logic [NUM_RD*DATA_WIDTH-1:0]   rs_data,
   output logic [NUM_RD-1:0]              rs_busy,
   input  logic                           wb_en,
   input  logic [ADDR_WIDTH-1:0]          wb_addr,
   input  logic [DATA_WIDTH-1:0]          wb_data,
   input  logic                           iss_en,
   input  logic [ADDR_WIDTH-1:0]          iss_addr,
   input  logic                           flush,
   output logic [ADDR_WIDTH:0]            busy_cnt
);
   localparam int NREG = 1 << ADDR_WIDTH;
   localparam logic [ADDR_WIDTH-1:0] ZERO = ADDR_WIDTH'(SB_ZERO_REG);

   logic [DATA_WIDTH-1:0] data_q [NREG];
   logic [NREG-1:0]       busy_vec;

   busy_tracker #(.ADDR_WIDTH(ADDR_WIDTH)) u_busy (
      .clk      (clk),
      .rst_n    (rst_n),
      .iss_en   (iss_en),
      .iss_addr (iss_addr),
      .wb_en    (wb_en),
      .wb_addr  (wb_addr),
      .flush    (flush),
      .busy_o   (busy_vec),
      .cnt_o    (busy_cnt)
   );

   // Entry 0 is never written so it stays at its reset value of zero.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NREG; i++) data_q[i] <= '0;
      end else if (wb_en && wb_addr != ZERO) begin
         data_q[wb_addr] <= wb_data;
      end
   end

   for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
      logic [ADDR_WIDTH-1:0] a;
      logic                  byp;
      assign a   = rs_addr[k*ADDR_WIDTH +: ADDR_WIDTH];
      // Bypass is suppressed in reset so held-in-reset reads stay zero.
      assign byp = rst_n && wb_en && (wb_addr == a) && (a != ZERO);
      assign rs_data[k*DATA_WIDTH +: DATA_WIDTH] =
         (a == ZERO) ? '0 : (byp ? wb_data : data_q[a]);
      assign rs_busy[k] = ~byp & busy_vec[a];
   end

`ifdef SCOREBOARD_REGFILE_LOG
   always @(posedge clk) begin
      if (rst_n && wb_en && wb_addr != ZERO)
         $display("[regfile] x%0d <= %h", wb_addr, wb_data);
      if (rst_n && iss_en && iss_addr != ZERO && !flush)
         $display("[regfile] x%0d pending", iss_addr);
   end
`endif
endmodule

// File: tb/tb_scoreboard_regfile.sv
// Randomized bench for scoreboard_regfile against an array-based reference
// model, plus directed scenarios for bypass, hazards, flush and reset.
module tb_scoreboard_regfile;
   localparam int AW = 5;
   localparam int DW = 64;
   localparam int NR = 2;

   logic             clk = 1'b0;
   logic             rst_n;
   logic [NR*AW-1:0] rs_addr;
   logic [NR*DW-1:0] rs_data;
   logic [NR-1:0]    rs_busy;
   logic             wb_en;
   logic [AW-1:0]    wb_addr;
   logic [DW-1:0]    wb_data;
   logic             iss_en;
   logic [AW-1:0]    iss_addr;
   logic             flush;
   logic [AW:0]      busy_cnt;

   int n_cmp = 0;
   int n_err = 0;

   logic [DW-1:0] m_data [32];
   bit            m_busy [32];

   scoreboard_regfile #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_RD(NR)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .rs_addr  (rs_addr),
      .rs_data  (rs_data),
      .rs_busy  (rs_busy),
      .wb_en    (wb_en),
      .wb_addr  (wb_addr),
      .wb_data  (wb_data),
      .iss_en   (iss_en),
      .iss_addr (iss_addr),
      .flush    (flush),
      .busy_cnt (busy_cnt)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h @%0t", tag, obs, exp, $time);
      end
   endtask

   function automatic logic [DW-1:0] m_rd(input logic [AW-1:0] a);
      if (a == 0) return '0;
      if (wb_en && wb_addr == a) return wb_data;
      return m_data[a];
   endfunction

   function automatic bit m_bz(input logic [AW-1:0] a);
      if (a == 0) return 1'b0;
      if (wb_en && wb_addr == a) return 1'b0;
      return m_busy[a];
   endfunction

   function automatic int m_cnt();
      int c = 0;
      for (int i = 0; i < 32; i++) c += m_busy[i];
      return c;
   endfunction

   task automatic m_clear();
      for (int i = 0; i < 32; i++) begin
         m_data[i] = '0;
         m_busy[i] = 1'b0;
      end
   endtask

   task automatic drive(input bit we, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                        input bit ie, input logic [AW-1:0] ia, input bit fl,
                        input logic [AW-1:0] r0, input logic [AW-1:0] r1);
      wb_en = we; wb_addr = wa; wb_data = wd;
      iss_en = ie; iss_addr = ia; flush = fl;
      rs_addr = {r1, r0};
   endtask

   task automatic idle(input logic [AW-1:0] r0, input logic [AW-1:0] r1);
      drive(0, 0, 0, 0, 0, 0, r0, r1);
      #1;
   endtask

   // Check combinational outputs against the model, then take one edge.
   task automatic cyc();
      @(negedge clk);
      for (int k = 0; k < NR; k++) begin
         chk("rd_data", rs_data[k*DW +: DW], m_rd(rs_addr[k*AW +: AW]));
         chk("rd_busy", DW'(rs_busy[k]), DW'(m_bz(rs_addr[k*AW +: AW])));
      end
      chk("busy_cnt", DW'(busy_cnt), DW'(m_cnt()));
      @(posedge clk);
      if (wb_en && wb_addr != 0) begin
         m_data[wb_addr] = wb_data;
         m_busy[wb_addr] = 1'b0;
      end
      if (iss_en && iss_addr != 0) m_busy[iss_addr] = 1'b1;
      if (flush) for (int i = 0; i < 32; i++) m_busy[i] = 1'b0;
      #1;
   endtask

   function automatic logic [AW-1:0] rnd_addr();
      return ($urandom_range(0, 1) == 0) ? AW'($urandom_range(0, 7)) : AW'($urandom_range(0, 31));
   endfunction

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      m_clear();
      rst_n = 1'b0;
      drive(0, 0, 0, 0, 0, 0, 0, 0);
      #3;
      for (int a = 0; a < 32; a++) begin
         rs_addr = {AW'(a), AW'(a)};
         #1;
         for (int k = 0; k < NR; k++) begin
            chk("rst_data", rs_data[k*DW +: DW], '0);
            chk("rst_busy", DW'(rs_busy[k]), '0);
         end
      end
      chk("rst_cnt", DW'(busy_cnt), '0);

      // Traffic while held in reset must be discarded.
      drive(1, 9, 64'h1234, 1, 10, 0, 9, 10);
      repeat (2) @(posedge clk);
      #1;
      chk("rst_wb_rd", rs_data[DW-1:0], '0);
      chk("rst_cnt2", DW'(busy_cnt), '0);
      idle(9, 10);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      cyc();

      // Same-cycle bypass, then persistence.
      drive(1, 5, 64'hDEAD, 0, 0, 0, 5, 0);
      cyc();
      idle(5, 0);
      chk("x5_persist", rs_data[DW-1:0], 64'hDEAD);

      // Issue then retire x7.
      drive(0, 0, 0, 1, 7, 0, 7, 7);
      cyc();
      idle(7, 0);
      chk("x7_busy", DW'(rs_busy[0]), 1);
      chk("x7_cnt", DW'(busy_cnt), 1);
      drive(1, 7, 64'h42, 0, 0, 0, 7, 0);
      cyc();
      idle(7, 0);
      chk("x7_clear", DW'(rs_busy[0]), 0);
      chk("x7_cnt0", DW'(busy_cnt), 0);
      chk("x7_data", rs_data[DW-1:0], 64'h42);

      // Issue and writeback to the same register: new producer wins.
      drive(1, 3, 64'h11, 1, 3, 0, 3, 0);
      cyc();
      idle(3, 0);
      chk("x3_data", rs_data[DW-1:0], 64'h11);
      chk("x3_busy", DW'(rs_busy[0]), 1);
      chk("x3_cnt", DW'(busy_cnt), 1);

      // Flush overrides a concurrent issue.
      for (int r = 1; r <= 3; r++) begin
         drive(0, 0, 0, 1, AW'(r), 0, AW'(r), 4);
         cyc();
      end
      idle(1, 4);
      chk("pre_flush_cnt", DW'(busy_cnt), 3);
      drive(0, 0, 0, 1, 4, 1, 4, 1);
      cyc();
      idle(4, 1);
      chk("flush_cnt", DW'(busy_cnt), 0);
      chk("flush_x4", DW'(rs_busy[0]), 0);

      // Register zero ignores writes and issues.
      drive(1, 0, 64'hFF, 1, 0, 0, 0, 0);
      cyc();
      idle(0, 0);
      chk("x0_data", rs_data[DW-1:0], '0);
      chk("x0_busy", DW'(rs_busy[0]), 0);
      chk("x0_cnt", DW'(busy_cnt), 0);

      // Randomized traffic against the model.
      for (int n = 0; n < 400; n++) begin
         drive($urandom_range(0, 2) != 0, rnd_addr(), {$urandom, $urandom},
               $urandom_range(0, 2) != 0, rnd_addr(),
               $urandom_range(0, 19) == 0, rnd_addr(), rnd_addr());
         cyc();
      end

      // Asynchronous reset mid-flight with x9 pending.
      drive(1, 9, 64'h99, 1, 9, 0, 9, 9);
      cyc();
      idle(9, 9);
      chk("x9_busy_pre", DW'(rs_busy[0]), 1);
      #1;
      rst_n = 1'b0;
      #1;
      chk("midrst_cnt", DW'(busy_cnt), 0);
      chk("midrst_x9", rs_data[DW-1:0], '0);
      chk("midrst_busy", DW'(rs_busy[0]), 0);
      m_clear();
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      for (int n = 0; n < 50; n++) begin
         drive($urandom_range(0, 1) != 0, rnd_addr(), {$urandom, $urandom},
               $urandom_range(0, 1) != 0, rnd_addr(),
               $urandom_range(0, 19) == 0, rnd_addr(), rnd_addr());
         cyc();
      end
      idle(0, 0);
      cyc();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
